// File: rtl/lsu_if.sv
// Execute-stage <-> load/store unit request/response bus.
// Both channels transfer on a rising edge where valid && ready; the sender keeps valid and payload stable until then.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_fault
   );
endinterface

// File: rtl/lsu.sv
// rv32i load/store unit: one request at a time, bounds/funct3 checks, one RAM access cycle, registered response.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of issuing byte-wise.
package lsu_pkg;
   typedef enum logic { MEM_NONE = 1'b0, MEM_STORE = 1'b1 } mem_op_e;
   typedef enum logic [1:0] { RAM_MASK_B = 2'd0, RAM_MASK_H = 2'd1, RAM_MASK_W = 2'd2 } ram_mask_e;
   typedef enum logic [1:0] { IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2 } lsu_state_e;
endpackage

module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_LENGTH = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_if.slave        bus,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output mem_op_e     ram_mem_op,
   output ram_mask_e   ram_mask,
   input  logic [31:0] ram_rdata,
   output lsu_state_e  dbg_state
);

   localparam logic [32:0] MEM_SIZE = 33'd1 << ADDR_LENGTH;

   lsu_state_e  state_q, state_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic        fault_q;
   logic [31:0] resp_rdata_q;
   logic        resp_fault_q;

   logic [2:0]  acc_size;
   logic [32:0] last_byte;
   logic        illegal_f3;
   logic        out_of_range;
   logic        misaligned;
   logic        req_fault;
   ram_mask_e   mask_sel;
   logic [31:0] ext_rdata;

   // Request checks; the 33-bit sum keeps accesses near 2^32 from wrapping into range.
   always_comb begin
      acc_size = 3'd4;
      mask_sel = RAM_MASK_W;
      case (bus.req_funct3[1:0])
         2'b00: begin acc_size = 3'd1; mask_sel = RAM_MASK_B; end
         2'b01: begin acc_size = 3'd2; mask_sel = RAM_MASK_H; end
         default: begin acc_size = 3'd4; mask_sel = RAM_MASK_W; end
      endcase
      last_byte    = {1'b0, bus.req_addr} + {30'd0, acc_size} - 33'd1;
      out_of_range = (last_byte >= MEM_SIZE);
      if (bus.req_we)
         illegal_f3 = bus.req_funct3[2] | (&bus.req_funct3[1:0]);
      else
         illegal_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
      misaligned = 1'b0;
`endif
      req_fault = illegal_f3 | out_of_range | misaligned;
   end

   always_comb begin
      case (funct3_q)
         3'b000:  ext_rdata = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
         3'b001:  ext_rdata = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
         3'b100:  ext_rdata = {24'd0, ram_rdata[7:0]};
         3'b101:  ext_rdata = {16'd0, ram_rdata[15:0]};
         default: ext_rdata = ram_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      ram_mem_op     = MEM_NONE;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = ACCESS;
         end
         ACCESS: begin
            if (we_q && !fault_q) ram_mem_op = MEM_STORE;
            state_d = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM-side fields are latched at accept and held until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr     <= 32'd0;
         ram_wdata    <= 32'd0;
         ram_mask     <= RAM_MASK_W;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         fault_q      <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_fault_q <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.req_valid) begin
            ram_addr  <= bus.req_addr;
            ram_wdata <= bus.req_wdata;
            ram_mask  <= mask_sel;
            we_q      <= bus.req_we;
            funct3_q  <= bus.req_funct3;
            fault_q   <= req_fault;
         end
         if (state_q == ACCESS) begin
            resp_fault_q <= fault_q;
            resp_rdata_q <= (fault_q || we_q) ? 32'd0 : ext_rdata;
         end
      end
   end

   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_fault = resp_fault_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: attached byte RAM, transaction-level reference model, directed and random requests.
module tb_lsu;
   import lsu_pkg::*;

   localparam int MEM_SIZE = 1024;

   logic        clk;
   logic        rst_n;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   mem_op_e     ram_mem_op;
   ram_mask_e   ram_mask;
   logic [31:0] ram_rdata;
   lsu_state_e  dbg_state;

   lsu_if bus();

   lsu #(.ADDR_LENGTH(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_mem_op(ram_mem_op),
      .ram_mask  (ram_mask),
      .ram_rdata (ram_rdata),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // attached RAM: combinational read, write on the rising edge
   logic [7:0] ram_mem [MEM_SIZE];
   logic [9:0] ra;
   assign ra = ram_addr[9:0];
   assign ram_rdata = {ram_mem[ra + 10'd3], ram_mem[ra + 10'd2], ram_mem[ra + 10'd1], ram_mem[ra]};

   always @(posedge clk) begin
      if (ram_mem_op == MEM_STORE) begin
         ram_mem[ra] <= ram_wdata[7:0];
         if (ram_mask != RAM_MASK_B) ram_mem[ra + 10'd1] <= ram_wdata[15:8];
         if (ram_mask == RAM_MASK_W) begin
            ram_mem[ra + 10'd2] <= ram_wdata[23:16];
            ram_mem[ra + 10'd3] <= ram_wdata[31:24];
         end
      end
   end

   int store_cnt = 0;
   always @(negedge clk) if (ram_mem_op == MEM_STORE) store_cnt++;

   // scoreboard
   logic [7:0]  ref_mem [MEM_SIZE];
   logic [32:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference: returns {fault, rdata}; applies non-faulting stores to ref_mem.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [32:0] exp);
      int     size;
      bit     illegal, oor, mis;
      longint last, v;
      int     a;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      last = longint'(addr) + longint'(size) - 1;
      oor = (last >= longint'(MEM_SIZE));
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (longint'(addr) % longint'(size)) != 0;
`else
      mis = 1'b0;
`endif
      if (illegal || oor || mis) begin
         exp = {1'b1, 32'd0};
      end else begin
         a = int'(addr[9:0]);
         if (we) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wdata[8*i +: 8];
            exp = 33'd0;
         end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_mem[a + i]) << (8 * i);
            if (f3[2] == 1'b0 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
               v -= (longint'(1) << (8 * size));
            exp = {1'b0, v[31:0]};
         end
      end
   endtask

   // driver: one full request/response transaction, holding resp_ready low for 'hold' cycles
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] got_rdata, output logic got_fault);
      logic [32:0] exp;
      logic [31:0] held;
      int cyc;
      int st0;
      model(we, f3, addr, wdata, exp);
      exp_q.push_back(exp);
      @(negedge clk);
      check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.resp_ready = (hold == 0);
      st0 = store_cnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.resp_valid && cyc < 10);
      check("latency", 32'(cyc), 32'd2);
      if (hold > 0) begin
         held = bus.resp_rdata;
         for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("hold_rdata", bus.resp_rdata, held);
            @(negedge clk);
         end
         bus.resp_ready = 1'b1;
      end
      exp = exp_q.pop_front();
      got_rdata = bus.resp_rdata;
      got_fault = bus.resp_fault;
      check("rdata", got_rdata, exp[31:0]);
      check("fault", {31'd0, got_fault}, {31'd0, exp[32]});
      check("store_issued", 32'(store_cnt - st0), (we && !exp[32]) ? 32'd1 : 32'd0);
   endtask

   logic [31:0] r;
   logic        f;
   logic [32:0] dummy;
   logic [2:0]  ld_f3 [5];
   logic [2:0]  st_f3 [3];

   initial begin
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      st_f3 = '{3'd0, 3'd1, 3'd2};
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
      check("rst_ram_addr", ram_addr, 32'd0);
      check("rst_ram_wdata", ram_wdata, 32'd0);
      check("rst_ram_mem_op", 32'(ram_mem_op), 32'(MEM_NONE));
      check("rst_ram_mask", 32'(ram_mask), 32'(RAM_MASK_W));
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;

      // fill every word so the RAM and the reference agree everywhere
      for (int w = 0; w < MEM_SIZE / 4; w++) run_req(1'b1, 3'd2, 32'(w * 4), $urandom, 0, r, f);

      run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, r, f);
      run_req(1'b1, 3'd2, 32'h14, 32'h44332211, 0, r, f);
      run_req(1'b0, 3'd2, 32'h10, 32'd0, 0, r, f);
      check("lw_10", r, 32'hDEADBEEF);
      run_req(1'b0, 3'd0, 32'h13, 32'd0, 0, r, f);
      check("lb_13", r, 32'hFFFFFFDE);
      run_req(1'b0, 3'd4, 32'h13, 32'd0, 0, r, f);
      check("lbu_13", r, 32'h000000DE);
      run_req(1'b0, 3'd1, 32'h12, 32'd0, 0, r, f);
      check("lh_12", r, 32'hFFFFDEAD);
      run_req(1'b0, 3'd5, 32'h10, 32'd0, 0, r, f);
      check("lhu_10", r, 32'h0000BEEF);
      run_req(1'b1, 3'd2, 32'h3FE, 32'hCAFEF00D, 0, r, f);
      check("sw_3fe_fault", {31'd0, f}, 32'd1);
      run_req(1'b0, 3'd2, 32'h400, 32'd0, 0, r, f);
      check("lw_400_fault", {31'd0, f}, 32'd1);
      check("lw_400_rdata", r, 32'd0);
      run_req(1'b0, 3'd2, 32'h11, 32'd0, 0, r, f);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lw_11_fault", {31'd0, f}, 32'd1);
      check("lw_11_rdata", r, 32'd0);
`else
      check("lw_11_fault", {31'd0, f}, 32'd0);
      check("lw_11_rdata", r, 32'h11DEADBE);
`endif
      run_req(1'b0, 3'd3, 32'h10, 32'd0, 0, r, f);
      check("ld_f3_011_fault", {31'd0, f}, 32'd1);
      run_req(1'b1, 3'd4, 32'h10, 32'd0, 0, r, f);
      check("st_f3_100_fault", {31'd0, f}, 32'd1);

      // back-pressure, then IDLE one cycle after release
      run_req(1'b0, 3'd2, 32'h10, 32'd0, 5, r, f);
      @(negedge clk);
      check("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("release_resp_valid", {31'd0, bus.resp_valid}, 32'd0);

      // reset during the ACCESS cycle of a store: the write must not land
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'h12345678;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("mid_access_op", 32'(ram_mem_op), 32'(MEM_STORE));
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("midrst_ram_mem_op", 32'(ram_mem_op), 32'(MEM_NONE));
      check("midrst_ram_addr", ram_addr, 32'd0);
      check("midrst_ram_wdata", ram_wdata, 32'd0);
      check("midrst_ram_mask", 32'(ram_mask), 32'(RAM_MASK_W));
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      run_req(1'b0, 3'd2, 32'h20, 32'd0, 0, r, f);

      // random traffic
      for (int n = 0; n < 200; n++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr;
         we = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = st_f3[$urandom_range(0, 2)];
         else f3 = ld_f3[$urandom_range(0, 4)];
         case ($urandom_range(0, 5))
            0, 1:    addr = 32'($urandom_range(0, MEM_SIZE - 1)) & ~32'd3;
            2:       addr = 32'($urandom_range(0, MEM_SIZE - 1));
            3:       addr = 32'($urandom_range(MEM_SIZE - 8, MEM_SIZE + 3));
            4:       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            default: addr = $urandom;
         endcase
         run_req(we, f3, addr, $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, r, f);
      end

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
